sqrt_sum_pipe: RTL

Parametrised, fully pipelined block that computes res = isqrt(x0) + isqrt(x1) + … + isqrt(x[N_CH-1]) over N_CH unsigned channels of width W. It accepts one argument set per clock and produces one result per clock at a fixed latency. It generalises the three-operand square-root sum used in the arithmetic/pipelining section. The channel count, operand width and per-channel enable mask are configurable. The integer square root is built in, and pipeline registers update only on valid data to save dynamic power.

---
 rtl/sqrt_sum_pipe_if.sv | 26 ++
 rtl/sqrt_sum_pipe.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/sqrt_sum_pipe_if.sv
// rtl/sqrt_sum_pipe_if.sv - argument/result bundle for the pipelined square-root sum
// Ports: arg_vld, x (N_CH packed W-bit operands), ch_en (per-channel enable)
//        toward the block; res_vld, res (SW-bit sum) back from it.
interface sqrt_sum_pipe_if #(
    parameter int N_CH = 3,
    parameter int W    = 32
);
    localparam int RW = W / 2;
    localparam int SW = RW + $clog2(N_CH);

    logic               arg_vld;
    logic [N_CH*W-1:0]  x;
    logic [N_CH-1:0]    ch_en;
    logic               res_vld;
    logic [SW-1:0]      res;

    modport master (
        output arg_vld, x, ch_en,
        input  res_vld, res
    );

    modport slave (
        input  arg_vld, x, ch_en,
        output res_vld, res
    );
endinterface

// File: rtl/sqrt_sum_pipe.sv
// rtl/sqrt_sum_pipe.sv - fully pipelined sum of per-channel integer square roots
// Ports: clk (rising edge), rst (synchronous, active-high),
//        bus.slave: arg_vld/x/ch_en in, res_vld/res out.
// Latency is RW isqrt stages + clog2(N_CH) adder levels + one output register,
// counting the edge that samples arg_vld as the first.
module sqrt_sum_pipe #(
    parameter int N_CH = 3,
    parameter int W    = 32
) (
    input  logic          clk,
    input  logic          rst,
    sqrt_sum_pipe_if.slave bus
);
    localparam int RW  = W / 2;
    localparam int LV  = $clog2(N_CH);
    localparam int SW  = RW + LV;
    localparam int LVQ = (LV > 0) ? LV : 1;

    // Per-stage, per-channel isqrt state. Data is never reset; only valids are.
    logic [RW:0]     rem_q  [RW][N_CH];
    logic [RW-1:0]   root_q [RW][N_CH];
    logic [W-1:0]    rad_q  [RW][N_CH];
    logic            vld_q  [RW];
    logic [N_CH-1:0] en_q   [RW];

    logic [RW:0]     rem_d  [RW][N_CH];
    logic [RW-1:0]   root_d [RW][N_CH];
    logic [W-1:0]    rad_d  [RW][N_CH];
    logic            in_vld [RW];
    logic [N_CH-1:0] in_en  [RW];

    // One restoring digit: bring down the next two radicand bits and try
    // subtracting 4*root+1; success sets the next root bit.
    function automatic void isqrt_step(
        input  logic [RW:0]   rem_i,
        input  logic [RW-1:0] root_i,
        input  logic [W-1:0]  rad_i,
        output logic [RW:0]   rem_o,
        output logic [RW-1:0] root_o,
        output logic [W-1:0]  rad_o
    );
        logic [RW+2:0] tmp;
        logic [RW+2:0] trial;
        logic [RW+2:0] diff;
        logic [RW:0]   root_ext;
        tmp   = {rem_i, rad_i[W-1 -: 2]};
        trial = {1'b0, root_i, 2'b01};
        diff  = tmp - trial;
        if (tmp >= trial) begin
            rem_o    = diff[RW:0];
            root_ext = {root_i, 1'b1};
        end else begin
            rem_o    = tmp[RW:0];
            root_ext = {root_i, 1'b0};
        end
        root_o = root_ext[RW-1:0];
        rad_o  = rad_i << 2;
    endfunction

    always_comb begin
        in_vld[0] = bus.arg_vld;
        in_en[0]  = bus.ch_en;
        for (int k = 0; k < N_CH; k++) begin
            isqrt_step('0, '0, bus.x[k*W +: W], rem_d[0][k], root_d[0][k], rad_d[0][k]);
        end
        for (int s = 1; s < RW; s++) begin
            in_vld[s] = vld_q[s-1];
            in_en[s]  = en_q[s-1];
            for (int k = 0; k < N_CH; k++) begin
                isqrt_step(rem_q[s-1][k], root_q[s-1][k], rad_q[s-1][k],
                           rem_d[s][k], root_d[s][k], rad_d[s][k]);
            end
        end
    end

    // Data registers move only for a valid item, and per channel only if that
    // channel is enabled, so idle or masked lanes do not toggle.
    always_ff @(posedge clk) begin
        for (int s = 0; s < RW; s++) begin
            if (rst) begin
                vld_q[s] <= 1'b0;
            end else begin
                vld_q[s] <= in_vld[s];
            end
            if (in_vld[s]) begin
                en_q[s] <= in_en[s];
                for (int k = 0; k < N_CH; k++) begin
                    if (in_en[s][k]) begin
                        rem_q[s][k]  <= rem_d[s][k];
                        root_q[s][k] <= root_d[s][k];
                        rad_q[s][k]  <= rad_d[s][k];
                    end
                end
            end
        end
    end

    // Adder tree. Each level holds 2*N_CH slots so pairs can always be formed;
    // slots past the live operands are zero, which turns an odd operand's
    // pairwise add into a plain register pass-through.
    logic [SW-1:0] lvl_d      [LV+1][2*N_CH];
    logic          lvl_vld    [LV+1];
    logic [SW-1:0] tree_q     [LVQ][2*N_CH];
    logic          tree_vld_q [LVQ];

    always_comb begin
        lvl_vld[0] = vld_q[RW-1];
        for (int j = 0; j < N_CH; j++) begin
            // Disabled channels hold stale data; force them to zero here.
            lvl_d[0][j] = en_q[RW-1][j] ? SW'(root_q[RW-1][j]) : '0;
        end
        for (int j = N_CH; j < 2*N_CH; j++) begin
            lvl_d[0][j] = '0;
        end
        for (int l = 1; l <= LV; l++) begin
            lvl_vld[l] = tree_vld_q[l-1];
            for (int j = 0; j < 2*N_CH; j++) begin
                lvl_d[l][j] = (j < N_CH) ? tree_q[l-1][j] : '0;
            end
        end
    end

    if (LV > 0) begin : g_tree
        always_ff @(posedge clk) begin
            for (int l = 0; l < LV; l++) begin
                if (rst) begin
                    tree_vld_q[l] <= 1'b0;
                end else begin
                    tree_vld_q[l] <= lvl_vld[l];
                end
                if (lvl_vld[l]) begin
                    for (int j = 0; j < N_CH; j++) begin
                        tree_q[l][j] <= lvl_d[l][2*j] + lvl_d[l][2*j+1];
                    end
                end
            end
        end
    end else begin : g_no_tree
        always_comb begin
            tree_vld_q[0] = 1'b0;
            for (int j = 0; j < 2*N_CH; j++) begin
                tree_q[0][j] = '0;
            end
        end
    end

    logic          res_vld_q;
    logic [SW-1:0] res_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            res_vld_q <= 1'b0;
            res_q     <= '0;
        end else begin
            res_vld_q <= lvl_vld[LV];
            if (lvl_vld[LV]) begin
                res_q <= lvl_d[LV][0];
            end
        end
    end

    assign bus.res_vld = res_vld_q;
    assign bus.res     = res_q;
endmodule
